// File: rtl/skid_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing one stream port among NUM_INPUTS requesters.
// The output is the head of a 2-entry skid FIFO, so out_* and in_ready are all flop outputs.
module skid_stream_arbiter #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ID_WIDTH-1:0]              grant_id,
  output logic                             grant_active
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [NUM_INPUTS-1:0]   in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0]   head_data_q, head_data_d;
  logic                    head_last_q, head_last_d;
  logic                    head_valid_q, head_valid_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic                    skid_last_q, skid_last_d;
  logic                    skid_valid_q, skid_valid_d;

  logic [ID_WIDTH-1:0]     sel_id;
  logic                    sel_found;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    g_last;
  logic                    g_valid;
  logic                    g_ready;
  logic                    accept;
  logic                    dequeue;

  // Round-robin pick: indices above last_grant first, then wrap to the low ones.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (!sel_found && in_valid[i] && (ID_WIDTH'(i) > last_grant_q)) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (!sel_found && in_valid[i] && (ID_WIDTH'(i) <= last_grant_q)) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    head_data_d  = head_data_q;
    head_last_d  = head_last_q;
    head_valid_d = head_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;
    in_ready_d   = '0;
    g_data       = '0;
    g_last       = 1'b0;
    g_valid      = 1'b0;
    g_ready      = 1'b0;

    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (ID_WIDTH'(i) == grant_q) begin
        g_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        g_last  = in_last[i];
        g_valid = in_valid[i];
        g_ready = in_ready_q[i];
      end
    end

    accept  = (state_q == LOCKED) && g_valid && g_ready;
    dequeue = head_valid_q && out_ready;

    // Skid FIFO: head feeds the port directly, skid entry refills the head on dequeue.
    if (dequeue) begin
      if (skid_valid_q) begin
        head_data_d  = skid_data_q;
        head_last_d  = skid_last_q;
        head_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = g_data;
          skid_last_d = g_last;
        end
      end else begin
        head_valid_d = accept;
        if (accept) begin
          head_data_d = g_data;
          head_last_d = g_last;
        end
      end
    end else if (accept) begin
      if (!head_valid_q) begin
        head_data_d  = g_data;
        head_last_d  = g_last;
        head_valid_d = 1'b1;
      end else begin
        skid_data_d  = g_data;
        skid_last_d  = g_last;
        skid_valid_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_id;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && g_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready next cycle only if one more beat can land even without a dequeue.
    if ((state_d == LOCKED) && !(head_valid_d && skid_valid_d)) begin
      in_ready_d = NUM_INPUTS'(1) << grant_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= ID_WIDTH'(NUM_INPUTS - 1);
      last_grant_q <= ID_WIDTH'(NUM_INPUTS - 1);
      in_ready_q   <= '0;
      head_data_q  <= '0;
      head_last_q  <= 1'b0;
      head_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_ready_q   <= in_ready_d;
      head_data_q  <= head_data_d;
      head_last_q  <= head_last_d;
      head_valid_q <= head_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_data     = head_data_q;
  assign out_last     = head_last_q;
  assign out_valid    = head_valid_q;
  assign grant_id     = grant_q;
  assign grant_active = (state_q == LOCKED);

endmodule

// File: tb/tb_skid_stream_arbiter.sv
// Bench for skid_stream_arbiter: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_skid_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      grant_id;
  logic            grant_active;

  skid_stream_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .grant_active(grant_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: beats held by the arbiter as a plain queue of {last,data}.
  logic [8:0] mq[$];
  int         m_locked = 0;
  int         m_g = N - 1;
  int         m_last = N - 1;
  logic [N-1:0] m_ready = '0;
  int         m_acc;
  int         m_deq;
  int         m_found;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_locked = 0;
      m_g      = N - 1;
      m_last   = N - 1;
      m_ready  = '0;
    end else begin
      m_acc = (m_locked != 0 && in_valid[m_g] && m_ready[m_g]) ? 1 : 0;
      m_deq = (mq.size() != 0 && out_ready) ? 1 : 0;
      if (m_deq != 0) void'(mq.pop_front());
      if (m_acc != 0) mq.push_back({in_last[m_g], in_data[m_g*DW +: DW]});
      if (m_locked == 0) begin
        m_found = 0;
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (m_found == 0 && in_valid[idx]) begin
            m_found  = 1;
            m_g      = idx;
            m_locked = 1;
          end
        end
      end else if (m_acc != 0 && in_last[m_g]) begin
        m_last   = m_g;
        m_locked = 0;
      end
      m_ready = (m_locked != 0 && mq.size() < 2) ? N'(1) << m_g : '0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("out_data", 32'(out_data), 32'(mq[0][7:0]));
        check("out_last", 32'(out_last), 32'(mq[0][8]));
      end
      check("grant_active", 32'(grant_active), 32'(m_locked));
      check("grant_id", 32'(grant_id), 32'(m_g));
    end
  end

  // Logs of what the DUT actually emitted and granted, used for literal checks.
  logic [8:0] out_log[$];
  int         glog[$];
  logic       ga_prev = 1'b0;
  logic [N-1:0] acc_q = '0;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) out_log.push_back({out_last, out_data});
    acc_q <= in_valid & in_ready;
  end

  always @(negedge clk) begin
    if (!reset && grant_active && !ga_prev) glog.push_back(int'(grant_id));
    ga_prev = grant_active;
  end

  // Per-requester source buffers.
  logic [8:0] src[N][256];
  int         head[N];
  int         tail[N];
  int         acc_cnt[N];
  logic [N-1:0] hold = '0;

  task automatic load(input int i, input int base, input int len);
    if (head[i] == tail[i]) begin
      head[i] = 0;
      tail[i] = 0;
    end
    for (int b = 0; b < len; b++) begin
      src[i][tail[i]] = {(b == len - 1), 8'(base + b)};
      tail[i]++;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      acc_cnt[i] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc_q[i] && head[i] != tail[i]) begin
        head[i]++;
        acc_cnt[i]++;
      end
      if (head[i] != tail[i] && !hold[i]) begin
        in_valid[i] = 1'b1;
        in_data[i*DW +: DW] = src[i][head[i]][7:0];
        in_last[i] = src[i][head[i]][8];
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    clear_src();
    hold = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c = 0;
    while (out_log.size() < n && c < budget) begin
      step();
      c++;
    end
    check(name, 32'(out_log.size() >= n), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    int busy = 1;
    while (busy != 0 && c < 200) begin
      step();
      c++;
      busy = out_valid ? 1 : 0;
      for (int i = 0; i < N; i++) if (head[i] != tail[i]) busy = 1;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  logic [8:0] exp2[6];
  logic [8:0] exp4[3];
  logic [8:0] exp5[6];
  int         c6;

  initial begin
    clear_src();
    repeat (3) step();
    reset = 1'b0;

    // Reset values and a quiet period.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd3);
    repeat (10) step();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Two 3-beat packets on inputs 0 and 2.
    out_ready = 1'b1;
    out_log.delete();
    load(0, 'h10, 3);
    load(2, 'h30, 3);
    wait_log(6, 60, "wait_two_packets");
    exp2 = '{9'h010, 9'h011, 9'h112, 9'h030, 9'h031, 9'h132};
    for (int k = 0; k < 6; k++)
      check($sformatf("two_pkt_beat%0d", k), 32'(out_log[k]), 32'(exp2[k]));

    // Round robin with single-beat packets on all inputs.
    do_reset();
    glog.delete();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) load(i, 'h40 + i*16 + k, 1);
    begin
      int c = 0;
      while (glog.size() < 8 && c < 200) begin
        step();
        c++;
      end
      check("wait_rr_grants", 32'(glog.size() >= 8), 32'd1);
    end
    for (int k = 0; k < 8 && k < glog.size(); k++)
      check($sformatf("rr_grant%0d", k), 32'(glog[k]), 32'(k % N));
    wait_drain("drain_rr");

    // Downstream stall on input 1.
    clear_src();
    out_log.delete();
    out_ready = 1'b0;
    load(1, 'hA0, 3);
    repeat (8) step();
    check("stall_accepts", 32'(acc_cnt[1]), 32'd2);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_data", 32'(out_data), 32'hA0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_log(3, 30, "wait_stall_release");
    exp4 = '{9'h0A0, 9'h0A1, 9'h1A2};
    for (int k = 0; k < 3; k++)
      check($sformatf("stall_beat%0d", k), 32'(out_log[k]), 32'(exp4[k]));
    wait_drain("drain_stall");

    // Input 3 pauses mid-packet while input 0 waits.
    clear_src();
    out_log.delete();
    load(3, 'hC0, 4);
    c6 = 0;
    while (acc_cnt[3] < 1 && c6 < 30) begin
      step();
      c6++;
    end
    check("wait_in3_first", 32'(acc_cnt[3] >= 1), 32'd1);
    hold[3] = 1'b1;
    load(0, 'h50, 2);
    repeat (4) begin
      step();
      check("pause_grant_id", 32'(grant_id), 32'd3);
      check("pause_in_ready0", 32'(in_ready[0]), 32'd0);
    end
    hold[3] = 1'b0;
    wait_log(6, 60, "wait_pause_done");
    exp5 = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h1C3, 9'h050, 9'h151};
    for (int k = 0; k < 6; k++)
      check($sformatf("pause_beat%0d", k), 32'(out_log[k]), 32'(exp5[k]));
    wait_drain("drain_pause");

    // Reset in the middle of a 4-beat packet.
    clear_src();
    load(2, 'hE0, 4);
    c6 = 0;
    while (acc_cnt[2] < 1 && c6 < 30) begin
      step();
      c6++;
    end
    check("wait_in2_first", 32'(acc_cnt[2] >= 1), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    clear_src();
    load(3, 'h70, 1);
    load(1, 'h60, 1);
    glog.delete();
    step();
    reset = 1'b0;
    c6 = 0;
    while (glog.size() < 1 && c6 < 20) begin
      step();
      c6++;
    end
    check("wait_post_rst_grant", 32'(glog.size() >= 1), 32'd1);
    if (glog.size() >= 1) check("post_rst_grant", 32'(glog[0]), 32'd1);
    wait_drain("drain_post_rst");

    // Randomized traffic; the per-cycle model carries the checking.
    clear_src();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if (head[i] == tail[i] && $urandom_range(3) == 0)
          load(i, $urandom_range(255), 1 + $urandom_range(3));
        hold[i] = ($urandom_range(9) == 0);
      end
      step();
    end
    hold = '0;
    out_ready = 1'b1;
    wait_drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
